// File: rtl/char_gfx_pkg.sv
// char_gfx_pkg: shared text-mode geometry, glyph codes and pixel types.
package char_gfx_pkg;
  localparam int CELL_W = 8;
  localparam int CELL_H = 10;
  localparam int TEXT_ROWS = 48;
  localparam logic [5:0] BLANK_CODE = 6'h3F;
  localparam logic [5:0] BLOCK_CODE = 6'h24;
  typedef logic [5:0] rgb222_t;
  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic       hs;
    logic       vs;
    logic       von;
  } tap_t;
  localparam tap_t TAP_RST = '{x: '0, y: '0, hs: 1'b1, vs: 1'b1, von: 1'b0};
endpackage

// File: rtl/glyph_rom.sv
// glyph_rom: 64-code x 10-row x 8-pixel font with a registered read port.
module glyph_rom
  import char_gfx_pkg::*;
(
  input  logic       clk,
  input  logic [5:0] code,
  input  logic [3:0] row,
  output logic [7:0] bits
);
  logic [63:0] glyph;
  logic [7:0] bits_d, bits_q;
  always_comb begin
    glyph = '0;
    case (code)
      6'h00: glyph = 64'h3C666E7666663C00;
      6'h01: glyph = 64'h183818181818_7E00;
      6'h02: glyph = 64'h3C66060C30607E00;
      6'h03: glyph = 64'h3C66061C06663C00;
      6'h04: glyph = 64'h0C1C3C6C7E0C0C00;
      6'h05: glyph = 64'h7E607C0606663C00;
      6'h06: glyph = 64'h3C607C6666663C00;
      6'h07: glyph = 64'h7E060C1830303000;
      6'h08: glyph = 64'h3C66663C66663C00;
      6'h09: glyph = 64'h3C66663E060C3800;
      6'h0A: glyph = 64'h183C66667E666600;
      6'h0B: glyph = 64'h7C66667C66667C00;
      6'h0C: glyph = 64'h3C66606060663C00;
      6'h0D: glyph = 64'h786C6666666C7800;
      6'h0E: glyph = 64'h7E60607C60607E00;
      6'h0F: glyph = 64'h7E60607C60606000;
      6'h10: glyph = 64'h3C66606E66663E00;
      6'h11: glyph = 64'h6666667E66666600;
      6'h12: glyph = 64'h3C18181818183C00;
      6'h13: glyph = 64'h1E0C0C0C0C6C3800;
      6'h14: glyph = 64'h666C7870786C6600;
      6'h15: glyph = 64'h6060606060607E00;
      6'h16: glyph = 64'h63777F6B63636300;
      6'h17: glyph = 64'h66767E7E6E666600;
      6'h18: glyph = 64'h3C66666666663C00;
      6'h19: glyph = 64'h7C66667C60606000;
      6'h1A: glyph = 64'h3C666666663C0E00;
      6'h1B: glyph = 64'h7C66667C786C6600;
      6'h1C: glyph = 64'h3C66603C06663C00;
      6'h1D: glyph = 64'h7E18181818181800;
      6'h1E: glyph = 64'h6666666666663C00;
      6'h1F: glyph = 64'h66666666663C1800;
      6'h20: glyph = 64'h6363636B7F776300;
      6'h21: glyph = 64'h66663C183C666600;
      6'h22: glyph = 64'h6666663C18181800;
      6'h23: glyph = 64'h7E060C1830607E00;
      default: glyph = '0;
    endcase
    // Only the solid block reaches the two underline rows of the cell.
    bits_d = code == BLOCK_CODE ? (row < 4'(CELL_H) ? 8'hFF : 8'h00)
           : (row[3] || code == BLANK_CODE) ? 8'h00
           : glyph[{~row[2:0], 3'b000} +: 8];
  end
  always_ff @(posedge clk) bits_q <= bits_d;
  assign bits = bits_q;
endmodule

// File: rtl/char_pixel_gen.sv
// char_pixel_gen: renders text-mode character codes into RGB222 pixels with a blinking cursor underline.
module char_pixel_gen
  import char_gfx_pkg::*;
#(
  parameter int CHAR_LAT = 1,
  parameter int BLINK_FRAMES = 30,
  parameter int TEXT_COLS = 80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] char_in,
  input  logic [9:0] xcoor,
  input  logic [8:0] ycoor,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       video_on_in,
  input  rgb222_t    fg_color,
  input  rgb222_t    bg_color,
  input  logic       cursor_en,
  input  logic [6:0] cursor_col,
  input  logic [5:0] cursor_row,
  output rgb222_t    rgb_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       video_on_out
);
  localparam int CW = $clog2(CELL_W);
  tap_t dly_d [CHAR_LAT];
  tap_t dly_q [CHAR_LAT];
  tap_t a;
  logic [8:0] y_prev_d, y_prev_q;
  logic [3:0] row_cnt_d, row_cnt_q;
  logic [5:0] cell_row_d, cell_row_q;
  logic [5:0] frame_cnt_d, frame_cnt_q;
  logic blink_d, blink_q, vs_prev_d, vs_prev_q;
  logic [CW-1:0] col1_d, col1_q;
  logic hit1_d, hit1_q, hs1_d, hs1_q, vs1_d, vs1_q, von1_d, von1_q;
  rgb222_t rgb_d, rgb_q;
  logic hs2_d, hs2_q, vs2_d, vs2_q, von2_d, von2_q;
  logic [7:0] glyph_bits;
  logic y_new, row_wrap, tick, last_frame, pix;
  always_comb begin
    dly_d[0] = '{x: xcoor, y: ycoor, hs: hsync_in, vs: vsync_in, von: video_on_in};
    for (int i = 1; i < CHAR_LAT; i++) dly_d[i] = dly_q[i-1];
    a = dly_q[CHAR_LAT-1];
    // Row/cell position is tracked incrementally on each new scanline instead of dividing ycoor.
    y_new = a.y != y_prev_q;
    row_wrap = row_cnt_q == 4'(CELL_H - 1);
    y_prev_d = a.y;
    row_cnt_d = !y_new ? row_cnt_q : (a.y == '0 || row_wrap) ? '0 : row_cnt_q + 4'd1;
    cell_row_d = !y_new ? cell_row_q
               : a.y == '0 ? '0
               : !row_wrap ? cell_row_q
               : cell_row_q == 6'(TEXT_ROWS - 1) ? cell_row_q : cell_row_q + 6'd1;
    col1_d = a.x[CW-1:0];
    hit1_d = cursor_en && a.x[9:CW] == cursor_col && cell_row_d == cursor_row &&
             row_cnt_d >= 4'(CELL_H - 2) && cursor_col < 7'(TEXT_COLS) && cursor_row < 6'(TEXT_ROWS);
    hs1_d = a.hs;
    vs1_d = a.vs;
    von1_d = a.von;
    vs_prev_d = a.vs;
    tick = vs_prev_q && !a.vs;
    last_frame = frame_cnt_q == 6'(BLINK_FRAMES - 1);
    frame_cnt_d = !tick ? frame_cnt_q : last_frame ? '0 : frame_cnt_q + 6'd1;
    blink_d = tick && last_frame ? !blink_q : blink_q;
    pix = glyph_bits[~col1_q];
    rgb_d = !von1_q ? '0 : (pix || (hit1_q && blink_q)) ? fg_color : bg_color;
    hs2_d = hs1_q;
    vs2_d = vs1_q;
    von2_d = von1_q;
  end
  glyph_rom u_rom (.clk(clk), .code(char_in), .row(row_cnt_d), .bits(glyph_bits));
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHAR_LAT; i++) dly_q[i] <= TAP_RST;
      y_prev_q <= '0;
      row_cnt_q <= '0;
      cell_row_q <= '0;
      frame_cnt_q <= '0;
      blink_q <= 1'b1;
      vs_prev_q <= 1'b1;
      col1_q <= '0;
      hit1_q <= 1'b0;
      hs1_q <= 1'b1;
      vs1_q <= 1'b1;
      von1_q <= 1'b0;
      rgb_q <= '0;
      hs2_q <= 1'b1;
      vs2_q <= 1'b1;
      von2_q <= 1'b0;
    end else begin
      dly_q <= dly_d;
      y_prev_q <= y_prev_d;
      row_cnt_q <= row_cnt_d;
      cell_row_q <= cell_row_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q <= blink_d;
      vs_prev_q <= vs_prev_d;
      col1_q <= col1_d;
      hit1_q <= hit1_d;
      hs1_q <= hs1_d;
      vs1_q <= vs1_d;
      von1_q <= von1_d;
      rgb_q <= rgb_d;
      hs2_q <= hs2_d;
      vs2_q <= vs2_d;
      von2_q <= von2_d;
    end
  end
  assign rgb_out = rgb_q;
  assign hsync_out = hs2_q;
  assign vsync_out = vs2_q;
  assign video_on_out = von2_q;
endmodule

// File: doc/char_pixel_gen.md
Name: char_pixel_gen

Overview:
- Downstream of the character-row store; consumes its 6-bit character code per pixel clock and renders the actual VGA pixel.
- Glyph ROM lookup (8x10 cells), per-pixel bit select, cursor underline with frame-based blink, RGB222 colour mux.
- Delays hsync/vsync/video_on to stay aligned with the pixel output.

Parameters:
- CHAR_LAT, 1, cycles by which char_in lags the xcoor/ycoor presented on the same cycle; coordinates are delayed internally by this amount.
- BLINK_FRAMES, 30, frames per cursor blink half-period (1..63).
- TEXT_COLS, 80, cursor column range (cells per line).

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- char_in  in  6  character code from the row store; 6'h3F = blank
- xcoor  in  10  current pixel X (0..639)
- ycoor  in  9  current pixel Y (0..479)
- hsync_in  in  1  horizontal sync, active-low, aligned with xcoor
- vsync_in  in  1  vertical sync, active-low, aligned with xcoor
- video_on_in  in  1  active-display flag, aligned with xcoor
- fg_color  in  6  RGB222 foreground {r[1:0],g[1:0],b[1:0]}
- bg_color  in  6  RGB222 background
- cursor_en  in  1  cursor enable
- cursor_col  in  7  cursor cell column (0..79)
- cursor_row  in  6  cursor cell row (0..47)
- rgb_out  out  6  RGB222 pixel
- hsync_out  out  1  delayed hsync
- vsync_out  out  1  delayed vsync
- video_on_out  out  1  delayed video_on

Behaviour:
- Reset (rst=1 at posedge): rgb_out=0, hsync_out=1, vsync_out=1, video_on_out=0; all pipeline valid/sync shadows cleared to those values; row_cnt=0, cell_row=0, frame_cnt=0, blink_on=1.
- Alignment: xcoor/ycoor/syncs/video_on go through a CHAR_LAT-deep delay line (stage D) so they align with char_in.
- Row tracking (sequential, no divider): y_prev holds the last aligned ycoor. When aligned ycoor != y_prev: if ycoor==0, row_cnt<=0 and cell_row<=0; else if row_cnt==9, row_cnt<=0 and cell_row<=cell_row+1 (saturates at 47); else row_cnt<=row_cnt+1. y_prev reset value 0.
- Stage 1 (registered): glyph_bits <= ROM[char_in][row_cnt]. Also registered: col = x[2:0], cursor_hit = cursor_en & (x[9:3]==cursor_col) & (cell_row==cursor_row) & (row_cnt>=8), plus syncs and video_on.
- Stage 2 (registered): pix = glyph_bits[7-col] (bit 7 = leftmost pixel). rgb_out = !video_on ? 0 : (pix | (cursor_hit & blink_on)) ? fg_color : bg_color.
- Latency: char_in to rgb_out = 2 cycles. Syncs/video_on in to out = CHAR_LAT+2 cycles.
- Glyph ROM contents:
  - 64x10x8, synchronous read.
  - Codes 0x00-0x09 are digits; 0x0A-0x23 are A-Z; 0x24 is a solid block (all 10 rows 8'hFF); 0x25-0x3F are all-zero (0x3F is the blank code).
  - Rows 8-9 are 0 for every code except 0x24.
  - Anchors: code 0x00 row0 = 8'h3C; code 0x0A row0 = 8'h18.
- Blink:
  - Frame tick = falling edge of the delayed vsync (previous=1, current=0).
  - On a tick, if frame_cnt==BLINK_FRAMES-1, frame_cnt<=0 and blink_on<=~blink_on; else frame_cnt<=frame_cnt+1.
- Boundaries:
  - Cursor beyond range (col>=TEXT_COLS or row>=48) never matches.
  - Cursor and glyph pixel both set: fg.
  - xcoor outside 0..639 with video_on=0: rgb_out=0.
  - Reset mid-line: next pixel starts from the reset state; pipeline refill outputs 0 for 2 cycles.

Decomposition:
- Package char_gfx_pkg holds:
  - CELL_W=8, CELL_H=10, TEXT_ROWS=48
  - BLANK_CODE=6'h3F, BLOCK_CODE=6'h24
  - typedef rgb222_t (6 bits)
- Sub-module glyph_rom: clk, code[5:0], row[3:0] -> bits[7:0], registered output. It is Stage 1's ROM.

Test Plan:
- Reset held 3 cycles -> rgb_out=0, hsync_out=1, vsync_out=1, video_on_out=0 throughout and 2 cycles after release.
- Hold char_in=6'h24, fg=6'h3F, bg=6'h00, video_on=1, sweep x 0..7 on y=0 -> rgb_out=6'h3F on all 8 pixels, appearing 2 cycles after char_in.
- char_in=6'h0A, y=0, x=0..7 -> rgb sequence matches bits of 8'h18 (only x=3,4 fg). With char_in=6'h3F, all bg.
- Step ycoor 0..25 -> row_cnt wraps 9->0 at y=10 and y=20, and cell_row=2 at y=20. Jump ycoor to 0 -> row_cnt=0, cell_row=0.
- cursor_en=1, col=2, row=0, char 6'h3F, y=8: x=16..23 -> fg, other x -> bg. After 30 vsync falling edges, the same pixels -> bg. After 30 more, fg again.
- hsync_in/vsync_in/video_on_in pulse patterns with CHAR_LAT=1 -> outputs are identical patterns delayed exactly 3 cycles.
